// File: rtl/data_array_write_sink_pkg.sv
// Shared types and widths for the data-array write channel.
package dcache_wr_pkg;
  localparam int WAYS   = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;
  localparam int OFF_W  = 3;
  localparam int ROW_W  = ADDR_W - OFF_W;

  typedef struct packed {
    logic [WAYS-1:0]   way_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/data_array_write_sink_fifo.sv
// Circular write-request queue; exposes every slot and its valid bit so the
// owner can run an associative hazard search over the buffered writes.
module wr_fifo import dcache_wr_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  wr_req_t               push_dat,
  input  logic                  pop,
  output wr_req_t [DEPTH-1:0]   ent_dat,
  output logic    [DEPTH-1:0]   ent_vld,
  output logic    [PTR_W-1:0]   rd_ptr,
  output logic                  full,
  output logic                  empty
);
  wr_req_t [DEPTH-1:0] mem_q, mem_d;
  logic    [DEPTH-1:0] vld_q, vld_d;
  logic    [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic    [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Pop clears before push sets, so a full-then-refill slot stays valid.
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign ent_dat = mem_q;
  assign ent_vld = vld_q;
  assign rd_ptr  = rd_ptr_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
endmodule

// File: rtl/data_array_write_sink.sv
// Buffers data-array write requests and drains them into the SRAM when reads leave the port idle.
// Define DATA_ARRAY_WRITE_BYPASS_EN to forward way/data of the youngest colliding write.
module data_array_write_sink #(
  parameter int DEPTH  = 2,
  parameter int WAYS   = dcache_wr_pkg::WAYS,
  parameter int ADDR_W = dcache_wr_pkg::ADDR_W,
  parameter int DATA_W = dcache_wr_pkg::DATA_W,
  parameter int OFF_W  = dcache_wr_pkg::OFF_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_req_valid,
  output logic                    io_req_ready,
  input  logic [WAYS-1:0]         io_req_bits_way_en,
  input  logic [ADDR_W-1:0]       io_req_bits_addr,
  input  logic [DATA_W-1:0]       io_req_bits_data,
  input  logic                    io_rd_valid,
  input  logic [ADDR_W-1:0]       io_rd_addr,
  output logic                    io_sram_wen,
  output logic [WAYS-1:0]         io_sram_wmask,
  output logic [ADDR_W-OFF_W-1:0] io_sram_waddr,
  output logic [DATA_W-1:0]       io_sram_wdata,
  output logic                    io_busy,
  output logic                    io_rd_hit,
  output logic [WAYS-1:0]         io_rd_hit_way,
  output logic [DATA_W-1:0]       io_rd_hit_data
);
  import dcache_wr_pkg::wr_req_t;

  localparam int PTR_W = $clog2(DEPTH);

  wr_req_t [DEPTH-1:0] ent_dat;
  logic    [DEPTH-1:0] ent_vld;
  logic    [PTR_W-1:0] rd_ptr;
  logic                full, empty, push, issue;
  wr_req_t             head, push_dat;

  assign push_dat = '{way_en: io_req_bits_way_en, addr: io_req_bits_addr, data: io_req_bits_data};
  assign push     = io_req_valid && !full;
  assign head     = ent_dat[rd_ptr];
  // Zero-way heads are popped like real writes but never strobe the SRAM.
  assign issue    = ent_vld[rd_ptr] && !io_rd_valid && !reset;

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (issue),
    .ent_dat  (ent_dat),
    .ent_vld  (ent_vld),
    .rd_ptr   (rd_ptr),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    io_sram_wen   = issue && (head.way_en != '0);
    io_sram_wmask = '0;
    io_sram_waddr = '0;
    io_sram_wdata = '0;
    if (io_sram_wen) begin
      io_sram_wmask = head.way_en;
      io_sram_waddr = head.addr[ADDR_W-1:OFF_W];
      io_sram_wdata = head.data;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  logic [PTR_W-1:0] idx;
  always_comb begin
    io_rd_hit      = 1'b0;
    io_rd_hit_way  = '0;
    io_rd_hit_data = '0;
    idx            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (ent_vld[idx] && (ent_dat[idx].way_en != '0) &&
          (ent_dat[idx].addr[ADDR_W-1:OFF_W] == io_rd_addr[ADDR_W-1:OFF_W])) begin
        io_rd_hit = 1'b1;
`ifdef DATA_ARRAY_WRITE_BYPASS_EN
        io_rd_hit_way  = ent_dat[idx].way_en;
        io_rd_hit_data = ent_dat[idx].data;
`endif
      end
    end
  end

  assign io_req_ready = !full;
  assign io_busy      = !empty;
endmodule

// File: tb/tb_data_array_write_sink.sv
// Directed vector table plus randomized traffic against a queue-based reference.
module tb_data_array_write_sink;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid, io_req_ready;
  logic [3:0]  io_req_bits_way_en;
  logic [11:0] io_req_bits_addr;
  logic [63:0] io_req_bits_data;
  logic        io_rd_valid;
  logic [11:0] io_rd_addr;
  logic        io_sram_wen;
  logic [3:0]  io_sram_wmask;
  logic [8:0]  io_sram_waddr;
  logic [63:0] io_sram_wdata;
  logic        io_busy, io_rd_hit;
  logic [3:0]  io_rd_hit_way;
  logic [63:0] io_rd_hit_data;

  always #5 clock = ~clock;

  data_array_write_sink #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_bits_way_en(io_req_bits_way_en), .io_req_bits_addr(io_req_bits_addr),
    .io_req_bits_data(io_req_bits_data),
    .io_rd_valid(io_rd_valid), .io_rd_addr(io_rd_addr),
    .io_sram_wen(io_sram_wen), .io_sram_wmask(io_sram_wmask),
    .io_sram_waddr(io_sram_waddr), .io_sram_wdata(io_sram_wdata),
    .io_busy(io_busy), .io_rd_hit(io_rd_hit),
    .io_rd_hit_way(io_rd_hit_way), .io_rd_hit_data(io_rd_hit_data)
  );

  typedef struct {
    logic [3:0]  way;
    logic [11:0] addr;
    logic [63:0] data;
  } req_t;

  req_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic m_issue, m_accept, m_rst;
  req_t m_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then compare all outputs to the queue model.
  task automatic drive(input logic rst, input logic rv, input logic [3:0] way,
                       input logic [11:0] addr, input logic [63:0] data,
                       input logic rdv, input logic [11:0] rda);
    logic        e_ready, e_wen, e_hit;
    logic [3:0]  e_hway;
    logic [63:0] e_hdata;
    @(negedge clock);
    reset = rst; io_req_valid = rv; io_req_bits_way_en = way;
    io_req_bits_addr = addr; io_req_bits_data = data;
    io_rd_valid = rdv; io_rd_addr = rda;
    #1;
    e_ready  = (q.size() < DEPTH);
    m_issue  = (q.size() > 0) && !rdv && !rst;
    m_accept = rv && e_ready && !rst;
    m_rst    = rst;
    m_in     = '{way, addr, data};
    e_wen    = m_issue && (q[0].way != 4'd0);
    e_hit = 1'b0; e_hway = '0; e_hdata = '0;
    foreach (q[i])
      if (q[i].way != 4'd0 && (q[i].addr >> 3) == (rda >> 3)) begin
        e_hit = 1'b1; e_hway = q[i].way; e_hdata = q[i].data;
      end
`ifndef DATA_ARRAY_WRITE_BYPASS_EN
    e_hway = '0; e_hdata = '0;
`endif
    chk("ready", 64'(io_req_ready), 64'(e_ready));
    chk("wen",   64'(io_sram_wen),  64'(e_wen));
    chk("wmask", 64'(io_sram_wmask), e_wen ? 64'(q[0].way) : 64'd0);
    chk("waddr", 64'(io_sram_waddr), e_wen ? 64'(q[0].addr >> 3) : 64'd0);
    chk("wdata", io_sram_wdata, e_wen ? q[0].data : 64'd0);
    chk("busy",  64'(io_busy), 64'(q.size() != 0));
    chk("hit",   64'(io_rd_hit), 64'(e_hit));
    chk("hit_way",  64'(io_rd_hit_way), 64'(e_hway));
    chk("hit_data", io_rd_hit_data, e_hdata);
  endtask

  task automatic commit();
    @(posedge clock);
    if (m_rst) q.delete();
    else begin
      if (m_issue) void'(q.pop_front());
      if (m_accept) q.push_back(m_in);
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic [3:0] way,
                      input logic [11:0] addr, input logic [63:0] data,
                      input logic rdv, input logic [11:0] rda);
    drive(rst, rv, way, addr, data, rdv, rda);
    commit();
  endtask

  typedef struct {
    logic        rv;
    logic [3:0]  way;
    logic [11:0] addr;
    logic [63:0] data;
    logic        rdv;
    logic [11:0] rda;
    logic        e_ready, e_wen;
    logic [3:0]  e_wmask;
    logic [8:0]  e_waddr;
    logic [63:0] e_wdata;
    logic        e_busy, e_hit;
    logic [3:0]  e_hway;
    logic [63:0] e_hdata;
  } vec_t;

  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] DA = 64'hAAAA_0000_1111_2222;
  localparam logic [63:0] DB = 64'hBBBB_3333_4444_5555;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1, 4'b0010, 12'h0A8, D0, 0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 4'b0000, 12'h000, 0,  0, 12'h000, 1, 1, 4'b0010, 9'h015, D0, 1, 0, 0, 0};
    vt[2]  = '{0, 4'b0000, 12'h000, 0,  0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 4'b0000, 12'h100, 1,  0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 4'b0000, 12'h000, 0,  0, 12'h100, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[5]  = '{0, 4'b0000, 12'h000, 0,  0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{1, 4'b0001, 12'h080, DA, 1, 12'h080, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{1, 4'b0100, 12'h084, DB, 1, 12'h080, 1, 0, 0, 0, 0, 1, 1, 4'b0001, DA};
    vt[8]  = '{0, 4'b0000, 12'h000, 0,  1, 12'h080, 0, 0, 0, 0, 0, 1, 1, 4'b0100, DB};
    vt[9]  = '{0, 4'b0000, 12'h000, 0,  1, 12'h090, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[10] = '{0, 4'b0000, 12'h000, 0,  0, 12'h000, 0, 1, 4'b0001, 9'h010, DA, 1, 0, 0, 0};
    vt[11] = '{0, 4'b0000, 12'h000, 0,  0, 12'h000, 1, 1, 4'b0100, 9'h010, DB, 1, 0, 0, 0};
    vt[12] = '{0, 4'b0000, 12'h000, 0,  0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", 64'(io_req_ready), 64'd1);
    chk("rst_busy",  64'(io_busy), 64'd0);
    chk("rst_wen",   64'(io_sram_wen), 64'd0);
    commit();

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      logic [3:0]  hw;
      logic [63:0] hd;
      drive(0, vt[i].rv, vt[i].way, vt[i].addr, vt[i].data, vt[i].rdv, vt[i].rda);
      hw = vt[i].e_hway; hd = vt[i].e_hdata;
`ifndef DATA_ARRAY_WRITE_BYPASS_EN
      hw = '0; hd = '0;
`endif
      chk($sformatf("v%0d_ready", i), 64'(io_req_ready), 64'(vt[i].e_ready));
      chk($sformatf("v%0d_wen", i),   64'(io_sram_wen), 64'(vt[i].e_wen));
      chk($sformatf("v%0d_wmask", i), 64'(io_sram_wmask), 64'(vt[i].e_wmask));
      chk($sformatf("v%0d_waddr", i), 64'(io_sram_waddr), 64'(vt[i].e_waddr));
      chk($sformatf("v%0d_wdata", i), io_sram_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_busy", i),  64'(io_busy), 64'(vt[i].e_busy));
      chk($sformatf("v%0d_hit", i),   64'(io_rd_hit), 64'(vt[i].e_hit));
      chk($sformatf("v%0d_hway", i),  64'(io_rd_hit_way), 64'(hw));
      chk($sformatf("v%0d_hdata", i), io_rd_hit_data, hd);
      commit();
    end

    // Backpressure: three requests while reads hold the port for 5 cycles
    step(0, 1, 4'b0001, 12'h010, 64'h11, 1, 12'hFF8);
    step(0, 1, 4'b0010, 12'h020, 64'h22, 1, 12'hFF8);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 4'b0100, 12'h030, 64'h33, 1, 12'hFF8);
      chk("bp_ready_low", 64'(io_req_ready), 64'd0);
      chk("bp_no_wen", 64'(io_sram_wen), 64'd0);
      commit();
    end
    drive(0, 1, 4'b0100, 12'h030, 64'h33, 0, 12'hFF8);
    chk("bp_first_out", 64'(io_sram_wdata), 64'h11);
    chk("bp_full_while_drain", 64'(io_req_ready), 64'd0);
    commit();
    drive(0, 1, 4'b0100, 12'h030, 64'h33, 0, 12'hFF8);
    chk("bp_second_out", 64'(io_sram_wdata), 64'h22);
    chk("bp_third_accept", 64'(io_req_ready), 64'd1);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("bp_third_out", 64'(io_sram_wdata), 64'h33);
    commit();
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset with a full FIFO and the port free
    step(0, 1, 4'b1000, 12'h040, 64'h44, 1, 0);
    step(0, 1, 4'b1000, 12'h048, 64'h55, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rstfull_wen", 64'(io_sram_wen), 64'd0);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rstfull_busy",  64'(io_busy), 64'd0);
    chk("rstfull_ready", 64'(io_req_ready), 64'd1);
    commit();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rstfull_stale", 64'(io_sram_wen), 64'd0);
      commit();
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] way;
      int sel;
      sel = $urandom_range(0, 4);
      way = (sel == 4) ? 4'd0 : 4'(1 << sel);
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, way,
           12'($urandom_range(0, 63)), {$urandom, $urandom},
           $urandom_range(0, 9) < 4, 12'($urandom_range(0, 63)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
